rsa256_wrapper: RTL and testbench

RSA256_WRAPPER -- requirements
Module: rsa256_wrapper

---
 rtl/rsa256_wrapper.sv | 163 ++++++++++++++++
 tb/tb_rsa256_wrapper.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa256_wrapper.sv
// Avalon-MM UART front end for a 256-bit RSA core: loads n, d, then ciphertext blocks, and returns plaintext bytes.
// Latency: one status poll plus one data read per received byte; one start pulse per block; one status poll plus one write per sent byte.
// Backpressure: every Avalon request is held stable while i_avm_waitrequest is high. Macro RSA_WRAPPER_FULL_OUTPUT_EN selects 32 instead of 31 sent bytes.
module rsa256_wrapper (
    input  logic         i_clk,
    input  logic         i_rst_n,
    output logic [4:0]   o_avm_address,
    output logic         o_avm_read,
    input  logic [31:0]  i_avm_readdata,
    output logic         o_avm_write,
    output logic [31:0]  o_avm_writedata,
    input  logic         i_avm_waitrequest,
    output logic         o_rsa_start,
    output logic [255:0] o_rsa_a,
    output logic [255:0] o_rsa_d,
    output logic [255:0] o_rsa_n,
    input  logic [255:0] i_rsa_a_pow_d,
    input  logic         i_rsa_finished
);

    localparam logic [4:0] RX_BASE = 5'd0;
    localparam logic [4:0] TX_BASE = 5'd4;
    localparam logic [4:0] STATUS  = 5'd8;
    localparam int RX_READY_BIT = 7;
    localparam int TX_READY_BIT = 6;
`ifdef RSA_WRAPPER_FULL_OUTPUT_EN
    localparam logic [5:0] TX_LAST = 6'd31;
    localparam int         TX_MSB  = 255;
`else
    localparam logic [5:0] TX_LAST = 6'd30;
    localparam int         TX_MSB  = 247;
`endif

    typedef enum logic [2:0] {
        S_QUERY_RX, S_READ, S_START, S_CALC, S_QUERY_TX, S_WRITE
    } state_t;
    typedef enum logic [1:0] {KEY_N, KEY_D, DATA} phase_t;

    state_t         state_q;
    phase_t         phase_q;
    logic [5:0]     cnt_q;
    logic [4:0]     addr_q;
    logic           read_q;
    logic           write_q;
    logic [31:0]    wdata_q;
    logic           start_q;
    logic [255:0]   n_q, d_q, a_q, out_q;

    logic           rd_done;
    logic           wr_done;
    logic [7:0]     rx_byte;
    logic           unused_readdata;

    assign rd_done = read_q && !i_avm_waitrequest;
    assign wr_done = write_q && !i_avm_waitrequest;
    assign rx_byte = i_avm_readdata[7:0];
    assign unused_readdata = ^i_avm_readdata[31:8];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_QUERY_RX;
            phase_q <= KEY_N;
            cnt_q   <= 6'd0;
            addr_q  <= STATUS;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= 32'd0;
            start_q <= 1'b0;
            n_q     <= 256'd0;
            d_q     <= 256'd0;
            a_q     <= 256'd0;
            out_q   <= 256'd0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_QUERY_RX: begin
                    // A not-ready poll drops read for one cycle before the next poll.
                    if (!read_q) begin
                        read_q <= 1'b1;
                    end else if (rd_done) begin
                        read_q <= 1'b0;
                        if (i_avm_readdata[RX_READY_BIT]) begin
                            state_q <= S_READ;
                            addr_q  <= RX_BASE;
                        end
                    end
                end
                S_READ: begin
                    if (!read_q) begin
                        read_q <= 1'b1;
                    end else if (rd_done) begin
                        read_q <= 1'b0;
                        addr_q <= STATUS;
                        case (phase_q)
                            KEY_N:   n_q <= {n_q[247:0], rx_byte};
                            KEY_D:   d_q <= {d_q[247:0], rx_byte};
                            default: a_q <= {a_q[247:0], rx_byte};
                        endcase
                        if (cnt_q == 6'd31) begin
                            cnt_q   <= 6'd0;
                            state_q <= (phase_q == DATA) ? S_START : S_QUERY_RX;
                            if (phase_q == KEY_N)      phase_q <= KEY_D;
                            else if (phase_q == KEY_D) phase_q <= DATA;
                        end else begin
                            cnt_q   <= cnt_q + 6'd1;
                            state_q <= S_QUERY_RX;
                        end
                    end
                end
                S_START: begin
                    start_q <= 1'b1;
                    state_q <= S_CALC;
                end
                S_CALC: begin
                    if (i_rsa_finished) begin
                        out_q   <= i_rsa_a_pow_d;
                        state_q <= S_QUERY_TX;
                    end
                end
                S_QUERY_TX: begin
                    if (!read_q) begin
                        read_q <= 1'b1;
                    end else if (rd_done) begin
                        read_q <= 1'b0;
                        if (i_avm_readdata[TX_READY_BIT]) begin
                            state_q <= S_WRITE;
                            addr_q  <= TX_BASE;
                        end
                    end
                end
                S_WRITE: begin
                    if (!write_q) begin
                        write_q <= 1'b1;
                        wdata_q <= {24'd0, out_q[TX_MSB -: 8]};
                    end else if (wr_done) begin
                        write_q <= 1'b0;
                        addr_q  <= STATUS;
                        out_q   <= out_q << 8;
                        if (cnt_q == TX_LAST) begin
                            // Keys stay loaded; only a new ciphertext follows.
                            cnt_q   <= 6'd0;
                            state_q <= S_QUERY_RX;
                        end else begin
                            cnt_q   <= cnt_q + 6'd1;
                            state_q <= S_QUERY_TX;
                        end
                    end
                end
                default: state_q <= S_QUERY_RX;
            endcase
        end
    end

    assign o_avm_address   = addr_q;
    assign o_avm_read      = read_q;
    assign o_avm_write     = write_q;
    assign o_avm_writedata = wdata_q;
    assign o_rsa_start     = start_q;
    assign o_rsa_a         = a_q;
    assign o_rsa_d         = d_q;
    assign o_rsa_n         = n_q;

endmodule

// File: tb/tb_rsa256_wrapper.sv
// Randomized bench: a UART/Avalon slave model, an RSA core model and a byte-stream scoreboard for rsa256_wrapper.
module tb_rsa256_wrapper;

`ifdef RSA_WRAPPER_FULL_OUTPUT_EN
    localparam int         TXN      = 32;
    localparam logic [7:0] FIRST_TX = 8'h00;
`else
    localparam int         TXN      = 31;
    localparam logic [7:0] FIRST_TX = 8'hAB;
`endif
    localparam logic [255:0] N_LIT =
        256'hCA3586E7EA485F3B0A222A4C79F7DD12E85388EECCDEE4BC2A39E5D5C2A9C8AB;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic [4:0]   o_avm_address;
    logic         o_avm_read;
    logic [31:0]  i_avm_readdata = 32'd0;
    logic         o_avm_write;
    logic [31:0]  o_avm_writedata;
    logic         i_avm_waitrequest = 1'b0;
    logic         o_rsa_start;
    logic [255:0] o_rsa_a, o_rsa_d, o_rsa_n;
    logic [255:0] i_rsa_a_pow_d = 256'd0;
    logic         i_rsa_finished = 1'b0;

    always #5 i_clk = ~i_clk;

    rsa256_wrapper dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .o_avm_address(o_avm_address), .o_avm_read(o_avm_read),
        .i_avm_readdata(i_avm_readdata), .o_avm_write(o_avm_write),
        .o_avm_writedata(o_avm_writedata), .i_avm_waitrequest(i_avm_waitrequest),
        .o_rsa_start(o_rsa_start), .o_rsa_a(o_rsa_a), .o_rsa_d(o_rsa_d), .o_rsa_n(o_rsa_n),
        .i_rsa_a_pow_d(i_rsa_a_pow_d), .i_rsa_finished(i_rsa_finished)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model state shared between the stimulus thread and the compare process.
    logic [7:0]   rxq[$];
    logic [7:0]   txq[$];
    logic [7:0]   tx_log[$];
    int           rx_notready = 0;
    int           force_wait_data = 0;
    int           wait_left = 0;
    int           stall_cycles_data = 0;
    int           idle_gaps = 0;
    bit           rand_mode = 0;
    bit           spur_req = 0;
    bit           pend = 0;
    logic [38:0]  p_req;
    bit           busy = 0;
    int           lat = 0;
    int           core_lat = 10;
    logic [255:0] result, snap_a, snap_d, snap_n;
    logic [255:0] exp_n, exp_d, exp_a;
    int           starts = 0;
    int           blocks_done = 0;
    bit           first_data = 0;
    bit           prev_notready = 0;

    always @(negedge i_clk) begin : compare_proc
        bit         stall, rx_ok, tx_ok;
        logic [7:0] b;
        if (!i_rst_n) begin
            pend = 0; busy = 0; wait_left = 0; prev_notready = 0;
            i_rsa_finished = 1'b0;
            i_avm_waitrequest = 1'b0;
            txq.delete();
        end else begin
            i_rsa_finished = 1'b0;
            chk(!(o_avm_read && o_avm_write), "rd_wr_exclusive", {o_avm_read, o_avm_write}, 0);
            if (prev_notready) begin
                chk(!o_avm_read, "poll_idle_gap", o_avm_read, 0);
                if (!first_data && !o_avm_read) idle_gaps++;
                prev_notready = 0;
            end
            if (pend)
                chk({o_avm_address, o_avm_read, o_avm_write, o_avm_writedata} == p_req, "avm_hold",
                    {o_avm_address, o_avm_read, o_avm_write, o_avm_writedata}, p_req);
            if (o_avm_read || o_avm_write) begin
                chk((o_avm_read && (o_avm_address == 5'd0 || o_avm_address == 5'd8)) ||
                    (o_avm_write && o_avm_address == 5'd4), "avm_address", o_avm_address, 0);
                if (!pend && o_avm_read && o_avm_address == 5'd0 && force_wait_data > 0) begin
                    wait_left = force_wait_data;
                    force_wait_data = 0;
                end
                if (wait_left > 0) begin
                    stall = 1;
                    wait_left--;
                    if (o_avm_address == 5'd0) stall_cycles_data++;
                end else begin
                    stall = rand_mode && ($urandom_range(0, 3) == 0);
                end
                i_avm_waitrequest = stall;
                if (stall) begin
                    pend = 1;
                    p_req = {o_avm_address, o_avm_read, o_avm_write, o_avm_writedata};
                    i_avm_readdata = $urandom;
                end else begin
                    pend = 0;
                    if (o_avm_read && o_avm_address == 5'd8) begin
                        rx_ok = rxq.size() > 0 && rx_notready == 0 && !(rand_mode && $urandom_range(0, 2) == 0);
                        if (rxq.size() > 0 && rx_notready > 0) rx_notready--;
                        tx_ok = !rand_mode || ($urandom_range(0, 1) == 1);
                        i_avm_readdata = {24'd0, rx_ok, tx_ok, 6'd0};
                        prev_notready = (txq.size() > 0) ? !tx_ok : !rx_ok;
                    end else if (o_avm_read) begin
                        first_data = 1;
                        chk(rxq.size() > 0, "rx_underflow", rxq.size(), 1);
                        i_avm_readdata = $urandom;
                        if (rxq.size() > 0) begin
                            b = rxq.pop_front();
                            i_avm_readdata[7:0] = b;
                        end
                    end else begin
                        chk(txq.size() > 0, "unexpected_write", o_avm_writedata, 0);
                        if (txq.size() > 0) begin
                            b = txq.pop_front();
                            chk(o_avm_writedata == {24'd0, b}, "tx_byte", o_avm_writedata, {24'd0, b});
                            tx_log.push_back(o_avm_writedata[7:0]);
                            if (txq.size() == 0) blocks_done++;
                        end
                    end
                end
            end else begin
                pend = 0;
                i_avm_waitrequest = ($urandom_range(0, 1) == 1);
            end
            // Core model: a start pulse must present the loaded operands and hold them until finished.
            if (o_rsa_start) begin
                chk(!busy, "start_single_pulse", busy, 0);
                starts++;
                busy = 1;
                lat = core_lat;
                chk(o_rsa_n == exp_n, "rsa_n_at_start", o_rsa_n, exp_n);
                chk(o_rsa_d == exp_d, "rsa_d_at_start", o_rsa_d, exp_d);
                chk(o_rsa_a == exp_a, "rsa_a_at_start", o_rsa_a, exp_a);
                snap_a = o_rsa_a; snap_d = o_rsa_d; snap_n = o_rsa_n;
            end else if (busy) begin
                chk(o_rsa_a == snap_a && o_rsa_d == snap_d && o_rsa_n == snap_n, "operands_stable", o_rsa_a, snap_a);
                lat--;
                if (lat == 0) begin
                    i_rsa_finished = 1'b1;
                    i_rsa_a_pow_d = result;
                    for (int i = 32 - TXN; i < 32; i++) txq.push_back(result[255 - 8*i -: 8]);
                    busy = 0;
                end
            end else if (spur_req) begin
                spur_req = 0;
                i_rsa_finished = 1'b1;
                i_rsa_a_pow_d = ~result;
            end
        end
    end

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic push_value(input logic [255:0] v);
        for (int i = 0; i < 32; i++) rxq.push_back(v[255 - 8*i -: 8]);
    endtask

    task automatic wait_blocks(input int k);
        int c = 0;
        while (blocks_done < k && c < 20000) begin
            @(posedge i_clk);
            c++;
        end
        chk(blocks_done >= k, "block_done_timeout", blocks_done, k);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(o_avm_address == 5'd8, {tag, "_address"}, o_avm_address, 5'd8);
        chk(!o_avm_read && !o_avm_write && !o_rsa_start, {tag, "_strobes"}, {o_avm_read, o_avm_write, o_rsa_start}, 0);
        chk(o_avm_writedata == 32'd0, {tag, "_writedata"}, o_avm_writedata, 0);
        chk(o_rsa_a == 0 && o_rsa_d == 0 && o_rsa_n == 0, {tag, "_operands"}, o_rsa_a | o_rsa_d | o_rsa_n, 0);
    endtask

    initial begin
        logic [255:0] r;
        int c;
        rx_notready = 3;
        force_wait_data = 5;
        repeat (3) @(posedge i_clk);
        #1 check_reset_outputs("reset");

        exp_n = N_LIT;
        exp_d = rand256();
        exp_d[255:240] = 16'h0B9A;
        exp_a = rand256();
        push_value(exp_n); push_value(exp_d); push_value(exp_a);
        r = rand256();
        result = {8'h00, 8'hAB, r[231:0], 8'hCD};
        @(posedge i_clk); #2 i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        chk(o_avm_read && o_avm_address == 5'd8, "first_read_after_reset", {o_avm_read, o_avm_address}, {1'b1, 5'd8});

        wait_blocks(1);
        chk(idle_gaps == 3, "idle_separated_polls", idle_gaps, 3);
        chk(stall_cycles_data == 5, "data_read_stall_cycles", stall_cycles_data, 5);
        chk(starts == 1, "starts_block1", starts, 1);
        chk(tx_log.size() == TXN, "tx_count_block1", tx_log.size(), TXN);
        if (tx_log.size() > 0) begin
            chk(tx_log[0] == FIRST_TX, "tx_first_byte", tx_log[0], FIRST_TX);
            chk(tx_log[tx_log.size() - 1] == 8'hCD, "tx_last_byte", tx_log[tx_log.size() - 1], 8'hCD);
        end
        chk(o_rsa_n == N_LIT, "n_literal", o_rsa_n, N_LIT);
        chk(o_rsa_d[255:240] == 16'h0B9A, "d_top_literal", o_rsa_d[255:240], 16'h0B9A);

        // Second ciphertext with the same keys, random stalls and a stray finished pulse.
        rand_mode = 1;
        core_lat = $urandom_range(1, 20);
        tx_log.delete();
        exp_a = rand256();
        result = rand256();
        push_value(exp_a);
        spur_req = 1;
        wait_blocks(2);
        chk(starts == 2, "starts_block2", starts, 2);
        chk(tx_log.size() == TXN, "tx_count_block2", tx_log.size(), TXN);

        // Third ciphertext is aborted by reset mid-computation.
        core_lat = 40;
        exp_a = rand256();
        result = rand256();
        push_value(exp_a);
        c = 0;
        while (starts < 3 && c < 20000) begin
            @(posedge i_clk);
            c++;
        end
        chk(starts == 3, "start_block3_timeout", starts, 3);
        repeat (3) @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(posedge i_clk); @(posedge i_clk);
        rxq.delete();
        exp_n = rand256(); exp_d = rand256(); exp_a = rand256();
        result = rand256();
        core_lat = $urandom_range(1, 20);
        push_value(exp_n); push_value(exp_d); push_value(exp_a);
        tx_log.delete();
        #2 i_rst_n = 1'b1;
        wait_blocks(3);
        chk(starts == 4, "starts_after_reset", starts, 4);
        chk(o_rsa_n == exp_n, "n_reloaded_after_reset", o_rsa_n, exp_n);
        chk(tx_log.size() == TXN, "tx_count_after_reset", tx_log.size(), TXN);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
